// File: rtl/inst_axi_responder_pkg.sv
// Shared encodings for the instruction fetch AXI responder: AXI burst/size codes,
// responder state codes and the default line length.
package inst_axi_responder_pkg;
  localparam int unsigned INST_LINE_WORDS = 4;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:4], 4'b0000};
  endfunction
endpackage

// File: rtl/inst_axi_responder_line_buf.sv
// One-line, four-word fetch buffer: storage, tag, valid flag and hit compare.
module inst_line_buf
  import inst_axi_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic        fill_done,
  input  logic [27:0] fill_tag,
  input  logic        fill_valid,
  input  logic [1:0]  rd_idx,
  output logic [31:0] rd_data,
  input  logic [27:0] lookup_tag,
  output logic        hit
);
  logic [31:0] mem_q [INST_LINE_WORDS];
  logic [31:0] mem_d [INST_LINE_WORDS];
  logic [27:0] tag_q, tag_d;
  logic        valid_q, valid_d;

  always_comb begin
    mem_d   = mem_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
    if (fill_done) begin
      tag_d   = fill_tag;
      valid_d = fill_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign hit     = valid_q && (tag_q == lookup_tag);
endmodule

// File: rtl/inst_axi_responder.sv
// Instruction fetch responder: SRAM-like fetch port to AXI4 read channel.
// INST_RESP_LINE_BUF_EN enables the 4-word line buffer; otherwise single-beat fetches.
module inst_axi_responder
  import inst_axi_responder_pkg::*;
#(
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter int unsigned LINE_WORDS = INST_LINE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_data_ok,
  output logic        inst_sram_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, araddr_q, araddr_d, rdata_q, rdata_d;
  logic [1:0]  beat_q, beat_d;
  logic        dropped_q, dropped_d, data_ok_q, data_ok_d;
  logic        hit_resp_q, hit_resp_d, err_q, err_d;
  logic        accept, hit, buf_wr, fill_done;
  logic [31:0] hit_word, miss_araddr;
  logic [1:0]  req_idx;

  assign inst_sram_stall = (state_q == ST_AR) || (state_q == ST_R);
  assign accept          = inst_sram_en && !inst_sram_stall;

`ifdef INST_RESP_LINE_BUF_EN
  logic fill_valid;
  // A line is only trusted if every beat was OKAY and the burst ran its full length.
  assign fill_valid = !err_q && (rresp == AXI_RESP_OKAY) &&
                      (beat_q == 2'(LINE_WORDS - 1));
  assign miss_araddr = line_base(inst_sram_addr);
  assign req_idx     = addr_q[3:2];
  assign arlen       = 8'(LINE_WORDS - 1);

  inst_line_buf u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (buf_wr),
    .wr_idx     (beat_q),
    .wr_data    (rdata),
    .fill_done  (fill_done),
    .fill_tag   (addr_q[31:4]),
    .fill_valid (fill_valid),
    .rd_idx     (inst_sram_addr[3:2]),
    .rd_data    (hit_word),
    .lookup_tag (inst_sram_addr[31:4]),
    .hit        (hit)
  );
`else
  assign miss_araddr = {inst_sram_addr[31:2], 2'b00};
  assign req_idx     = 2'b00;
  assign arlen       = 8'd0;
  assign hit         = 1'b0;
  assign hit_word    = '0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    beat_d     = beat_q;
    dropped_d  = dropped_q;
    err_d      = err_q;
    data_ok_d  = 1'b0;
    hit_resp_d = 1'b0;
    buf_wr     = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      ST_AR: begin
        if (flush)   dropped_d = 1'b1;
        if (arready) state_d   = ST_R;
      end
      ST_R: begin
        if (flush) dropped_d = 1'b1;
        if (rvalid) begin
          buf_wr = 1'b1;
          beat_d = beat_q + 2'd1;
          if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (beat_q == req_idx) rdata_d = rdata;
          if (rlast) begin
            state_d   = ST_RESP;
            fill_done = 1'b1;
            beat_d    = '0;
            data_ok_d = !dropped_q && !flush;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (hit) begin
            data_ok_d  = !flush;
            hit_resp_d = 1'b1;
            rdata_d    = hit_word;
          end else begin
            state_d   = ST_AR;
            addr_d    = inst_sram_addr;
            araddr_d  = miss_araddr;
            dropped_d = flush;
            beat_d    = '0;
            err_d     = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      araddr_q   <= '0;
      rdata_q    <= '0;
      beat_q     <= '0;
      dropped_q  <= 1'b0;
      data_ok_q  <= 1'b0;
      hit_resp_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      beat_q     <= beat_d;
      dropped_q  <= dropped_d;
      data_ok_q  <= data_ok_d;
      hit_resp_q <= hit_resp_d;
      err_q      <= err_d;
    end
  end

  // A hit response can still be withdrawn by flush in the cycle it is presented.
  assign inst_sram_data_ok = data_ok_q && !(flush && hit_resp_q);
  assign inst_sram_rdata   = rdata_q;
  assign arid              = AXI_ID;
  assign araddr            = araddr_q;
  assign arsize            = AXI_SIZE_4B;
  assign arburst           = AXI_BURST_INCR;
  assign arvalid           = (state_q == ST_AR);
  assign rready            = (state_q == ST_R);

  logic unused_sig;
  assign unused_sig = ^{rid, rresp, addr_q, err_q, buf_wr, fill_done,
                        inst_sram_addr[1:0], 32'(LINE_WORDS)};
endmodule
